// File: rtl/gb_timer_pkg.sv
// Shared definitions for the Game Boy style timer: register map, TAC tap table and
// reload sequencing states.
package gb_timer_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        TIMA = 2'd1,
        TMA  = 2'd2,
        TAC  = 2'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OVF_WAIT = 2'd1,
        RELOAD   = 2'd2
    } reload_state_e;

    // sys_cnt bit watched by TIMA for each TAC[1:0] setting
    localparam int unsigned TAP_SEL_00 = 9;
    localparam int unsigned TAP_SEL_01 = 3;
    localparam int unsigned TAP_SEL_10 = 5;
    localparam int unsigned TAP_SEL_11 = 7;

endpackage

// File: rtl/gb_tick_prescaler.sv
// Divides clk down to a one-cycle tick enable every TICK_DIV cycles; a clear restarts
// the count so the next tick lands TICK_DIV cycles later.
module gb_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gb_timer_unit.sv
// DIV/TIMA/TMA/TAC timer block: free-running system counter, falling-edge driven TIMA
// with delayed TMA reload and a one-cycle interrupt pulse.
module gb_timer_unit
    import gb_timer_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned TIMA_W     = 8,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned RELOAD_DLY = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [1:0]        addr,
    input  logic [TIMA_W-1:0] wdata,
    output logic [TIMA_W-1:0] rdata,
    output logic              irq,
    output logic [7:0]        div_out
);

    localparam logic [3:0]        RL_LAST  = 4'(RELOAD_DLY - 1);
    localparam logic [TIMA_W-1:0] TIMA_MAX = '1;

    logic                tick;
    logic [DIV_W-1:0]    sys_cnt_q, sys_cnt_d;
    logic [2:0]          tac_q, tac_d;
    logic [TIMA_W-1:0]   tima_q, tima_d;
    logic [TIMA_W-1:0]   tma_q, tma_d;
    logic [TIMA_W-1:0]   rdata_q, rdata_d;
    reload_state_e       state_q, state_d;
    logic [3:0]          rl_cnt_q, rl_cnt_d;
    logic                tap, tin, tin_q, fall;
    logic                wr_div, wr_tima, wr_tma, wr_tac;
    logic                reload_fire;
    logic [7:0]          div_val;

    assign wr_div  = wr_en && (addr == DIV);
    assign wr_tima = wr_en && (addr == TIMA);
    assign wr_tma  = wr_en && (addr == TMA);
    assign wr_tac  = wr_en && (addr == TAC);

    gb_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk_i (clk),
        .rst_i (Reset),
        .clr_i (wr_div),
        .tick_o(tick)
    );

    assign div_val = sys_cnt_q[DIV_W-1 -: 8];
    assign div_out = div_val;
    assign rdata   = rdata_q;
    assign irq     = (state_q == RELOAD);

    always_comb begin
        tap = 1'b0;
        unique case (tac_q[1:0])
            2'b00: tap = sys_cnt_q[TAP_SEL_00];
            2'b01: tap = sys_cnt_q[TAP_SEL_01];
            2'b10: tap = sys_cnt_q[TAP_SEL_10];
            2'b11: tap = sys_cnt_q[TAP_SEL_11];
            default: tap = 1'b0;
        endcase
    end

    // Any 1->0 of the gated tap counts, including ones caused by DIV or TAC writes.
    assign tin  = tap & tac_q[2];
    assign fall = tin_q & ~tin;

    assign reload_fire = (state_q == OVF_WAIT) && tick && (rl_cnt_q == RL_LAST);

    always_comb begin
        sys_cnt_d = sys_cnt_q;
        if (wr_div) begin
            sys_cnt_d = '0;
        end else if (tick) begin
            sys_cnt_d = sys_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        tac_d    = wr_tac ? wdata[2:0] : tac_q;
        tma_d    = wr_tma ? wdata : tma_q;
        tima_d   = tima_q;
        state_d  = state_q;
        rl_cnt_d = rl_cnt_q;
        unique case (state_q)
            OVF_WAIT: begin
                if (reload_fire) begin
                    // The reload clk ignores TIMA writes but honours a same-clk TMA write.
                    tima_d   = wr_tma ? wdata : tma_q;
                    state_d  = RELOAD;
                    rl_cnt_d = 4'd0;
                end else if (wr_tima) begin
                    tima_d   = wdata;
                    state_d  = IDLE;
                    rl_cnt_d = 4'd0;
                end else if (tick) begin
                    rl_cnt_d = rl_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                if (wr_tima) begin
                    tima_d = wdata;
                end else if (fall) begin
                    if (tima_q == TIMA_MAX) begin
                        tima_d   = '0;
                        state_d  = OVF_WAIT;
                        rl_cnt_d = 4'd0;
                    end else begin
                        tima_d = tima_q + TIMA_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (addr)
                DIV:     rdata_d = TIMA_W'(div_val);
                TIMA:    rdata_d = tima_q;
                TMA:     rdata_d = tma_q;
                TAC:     rdata_d = {{(TIMA_W-3){1'b1}}, tac_q};
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sys_cnt_q <= '0;
            tac_q     <= 3'd0;
            tima_q    <= '0;
            tma_q     <= '0;
            rdata_q   <= '0;
            state_q   <= IDLE;
            rl_cnt_q  <= 4'd0;
            tin_q     <= 1'b0;
        end else begin
            sys_cnt_q <= sys_cnt_d;
            tac_q     <= tac_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
            rl_cnt_q  <= rl_cnt_d;
            tin_q     <= tin;
        end
    end

endmodule

// File: doc/gb_timer_unit.md
GB_TIMER_UNIT -- requirements
Module: gb_timer_unit

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the internal system counter; legal range 10..16.
REQ-002 SHALL have parameter TIMA_W, default 8: width of TIMA and TMA; legal range 8..16.
REQ-003 SHALL have parameter TICK_DIV, default 1: clk cycles per timer tick; legal range 1..255.
REQ-004 SHALL have parameter RELOAD_DLY, default 4: ticks between TIMA overflow and TMA reload; legal range 1..15.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1: register write strobe, one write per clk.
REQ-008 SHALL have port rd_en, input, 1: register read strobe.
REQ-009 SHALL have port addr, input, 2: register select, 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
REQ-010 SHALL have port wdata, input, TIMA_W: write data.
REQ-011 SHALL have port rdata, output, TIMA_W: read data.
REQ-012 SHALL have port irq, output, 1: timer interrupt request pulse.
REQ-013 SHALL have port div_out, output, 8: live DIV value.

Function
REQ-014 SHALL advance a tick enable every TICK_DIV clk cycles; the prescaler wraps from TICK_DIV-1 to 0.
REQ-015 SHALL increment sys_cnt (DIV_W bits) by 1 per tick, wrapping modulo 2^DIV_W.
REQ-016 SHALL define DIV as sys_cnt[DIV_W-1:DIV_W-8].
REQ-017 SHALL clear sys_cnt and the prescaler to 0 on any write to addr 0; wdata is ignored.
REQ-018 SHALL use a TAC register of 3 bits: bit2 is the enable; bits1:0 select a tap on sys_cnt: 00→bit9, 01→bit3, 10→bit5, 11→bit7.
REQ-019 SHALL form the timer input as (selected tap AND TAC[2]), sampled each clk.
REQ-020 SHALL increment TIMA by 1 on each 1→0 transition of the timer input, from any cause: a count, a DIV write, a TAC write or disable.
REQ-021 SHALL, when TIMA overflows from all-ones, hold TIMA at 0 for RELOAD_DLY ticks; on the final tick it SHALL load TMA into TIMA and pulse irq high for exactly one clk.
REQ-022 SHALL, on a TIMA write during the reload window, cancel the pending reload and irq; TIMA takes wdata.
REQ-023 SHALL ignore a TIMA write on the reload clk itself; TMA is loaded.
REQ-024 SHALL, on a TMA write on the reload clk, load the new wdata into TIMA.
REQ-025 SHALL produce rdata registered, one clk after rd_en, from the values before any write in the same clk.
REQ-026 SHALL return TAC reads as ones in the upper TIMA_W-3 bits and TAC in the low 3 bits.
REQ-027 SHALL hold rdata when rd_en is low.
REQ-028 SHALL give an increment from REQ-020 priority over the tick in the same clk; a TIMA write in that clk wins over the increment.
REQ-029 SHALL drive div_out combinationally from DIV.

Reset
REQ-030 SHALL, on Reset assertion, clear immediately: sys_cnt, prescaler, TIMA, TMA, TAC, reload state, rdata, irq.
REQ-031 SHALL, on reset mid-reload, discard the pending irq.
REQ-032 SHALL produce the first tick TICK_DIV clks after Reset deasserts.

Structure
REQ-033 SHALL place in package gb_timer_pkg: the register address enum (DIV, TIMA, TMA, TAC), the tap-select table constants and the reload state enum (IDLE, OVF_WAIT, RELOAD).
REQ-034 SHALL contain one sub-module, gb_tick_prescaler, which generates the tick enable.
REQ-035 SHALL implement the rest of the logic inline in gb_timer_unit.

Verification
REQ-036 SHALL cover count: TAC=3'b101, TICK_DIV=1 → TIMA increments every 16 clks; 0x00→0x10 after 256 clks.
REQ-037 SHALL cover overflow and reload: TMA=0xF0, TIMA=0xFF, TAC=3'b101 → TIMA reads 0x00 for 4 ticks, then 0xF0; irq high exactly 1 clk.
REQ-038 SHALL cover cancel: TIMA write 0x42 in the second tick of the reload window → no irq; TIMA=0x42.
REQ-039 SHALL cover DIV-write glitch: TAC=3'b101, sys_cnt bit3=1, write DIV → TIMA +1; DIV reads 0x00.
REQ-040 SHALL cover reset mid-reload: assert Reset during OVF_WAIT → all registers 0, irq never pulses, rdata=0.
REQ-041 SHALL cover TAC read and prescale: write TAC=0x07 → read 0xFF (TIMA_W=8); TICK_DIV=4 → DIV increments every 1024 clks.
